// File: rtl/object_renderer.sv
// Sprite object renderer: per frame, erases each object at its previous position
// (if it was drawn last frame) and draws it at its new snapshot position.
// Pixels are emitted one slot per cycle with off-screen slots clipped.
module object_renderer #(
    parameter int unsigned N_OBJ     = 2,
    parameter int unsigned SPRITE_W  = 16,
    parameter int unsigned SPRITE_H  = 16,
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned COL_W     = 3,
    parameter int unsigned BG_COLOUR = 0
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   frame_tick,
    input  logic [N_OBJ-1:0]       obj_en,
    input  logic [N_OBJ*X_W-1:0]   obj_x,
    input  logic [N_OBJ*Y_W-1:0]   obj_y,
    input  logic [N_OBJ*COL_W-1:0] obj_colour,
    input  logic                   stall,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [COL_W-1:0]       colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int unsigned SLOTS = SPRITE_W * SPRITE_H;
    localparam int unsigned CNT_W = $clog2(SLOTS);
    localparam int unsigned COL_B = $clog2(SPRITE_W);
    localparam int unsigned IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOTS - 1);
    localparam logic [X_W:0]     SCR_W    = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0]     SCR_H    = (Y_W + 1)'(SCREEN_H);
    localparam logic [COL_W-1:0] BG       = COL_W'(BG_COLOUR);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StErase,
        StDraw,
        StNext,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_OBJ-1:0]     en_q;
    logic [N_OBJ*X_W-1:0] snap_x_q;
    logic [N_OBJ*Y_W-1:0] snap_y_q;
    logic [N_OBJ*COL_W-1:0] snap_col_q;
    logic [N_OBJ*X_W-1:0] prev_x_q;
    logic [N_OBJ*Y_W-1:0] prev_y_q;
    logic [N_OBJ-1:0]     prev_valid_q;
    logic                 overrun_q;

    logic             phase;
    logic             advance;
    logic             last;
    logic [IDX_W-1:0] idx_nxt;
    logic [X_W-1:0]   base_x;
    logic [Y_W-1:0]   base_y;
    logic [X_W:0]     xw;
    logic [Y_W:0]     yw;
    logic             on_screen;

    // First phase for an object: erase if it was drawn last frame, else draw, else nothing.
    function automatic state_e entry_state(input logic pv, input logic en);
        if (pv) begin
            return StErase;
        end else if (en) begin
            return StDraw;
        end
        return StNext;
    endfunction

    // Pixel address for the current slot, widened one bit so edge sprites never wrap.
    always_comb begin
        phase   = (state_q == StErase) || (state_q == StDraw);
        idx_nxt = idx_q + IDX_W'(1);
        last    = (cnt_q == LAST_CNT);
        if (state_q == StErase) begin
            base_x = prev_x_q[int'(idx_q)*X_W +: X_W];
            base_y = prev_y_q[int'(idx_q)*Y_W +: Y_W];
        end else begin
            base_x = snap_x_q[int'(idx_q)*X_W +: X_W];
            base_y = snap_y_q[int'(idx_q)*Y_W +: Y_W];
        end
        xw        = {1'b0, base_x} + (X_W + 1)'(cnt_q[COL_B-1:0]);
        yw        = {1'b0, base_y} + (Y_W + 1)'(cnt_q >> COL_B);
        on_screen = (xw < SCR_W) && (yw < SCR_H);
        // Clipped slots advance freely; visible ones wait for the sink.
        advance   = phase && !(on_screen && stall);
    end

    // Pixel outputs and status flags.
    always_comb begin
        x       = '0;
        y       = '0;
        colour  = '0;
        plot    = 1'b0;
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);
        overrun = overrun_q;
        if (phase) begin
            x      = xw[X_W-1:0];
            y      = yw[Y_W-1:0];
            colour = (state_q == StErase) ? BG : snap_col_q[int'(idx_q)*COL_W +: COL_W];
            plot   = on_screen;
        end
    end

    // Next-state logic: skipped phases are resolved here so they cost no cycles.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (frame_tick) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                idx_d   = '0;
                cnt_d   = '0;
                // Snapshot is being captured this cycle, so look at the live enable.
                state_d = entry_state(prev_valid_q[0], obj_en[0]);
            end
            StErase: begin
                if (advance) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last) begin
                        cnt_d   = '0;
                        state_d = en_q[idx_q] ? StDraw : StNext;
                    end
                end
            end
            StDraw: begin
                if (advance) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last) begin
                        cnt_d   = '0;
                        state_d = StNext;
                    end
                end
            end
            StNext: begin
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_nxt;
                    state_d = entry_state(prev_valid_q[idx_nxt], en_q[idx_nxt]);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, snapshot and previous-position registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            en_q         <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            snap_col_q   <= '0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            prev_valid_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (state_q == StLoad) begin
                en_q       <= obj_en;
                snap_x_q   <= obj_x;
                snap_y_q   <= obj_y;
                snap_col_q <= obj_colour;
            end
            if (state_q == StNext) begin
                prev_x_q[int'(idx_q)*X_W +: X_W] <= snap_x_q[int'(idx_q)*X_W +: X_W];
                prev_y_q[int'(idx_q)*Y_W +: Y_W] <= snap_y_q[int'(idx_q)*Y_W +: Y_W];
                prev_valid_q[idx_q]              <= en_q[idx_q];
            end
            if (frame_tick && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_object_renderer.sv
// Scoreboard bench for object_renderer: a frame-level model pushes expected pixels,
// a negedge monitor pops and compares every accepted pixel.
module tb_object_renderer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_tick = 1'b0;
    logic [1:0]  obj_en = '0;
    logic [15:0] obj_x = '0;
    logic [13:0] obj_y = '0;
    logic [5:0]  obj_colour = '0;
    logic        stall = 1'b0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done, overrun;

    object_renderer dut (
        .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .obj_en(obj_en),
        .obj_x(obj_x), .obj_y(obj_y), .obj_colour(obj_colour), .stall(stall),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int acc_cnt = 0;
    int smode = 0;
    bit stall_fired = 0;
    bit hold_prev = 0;
    int hold_pix = 0;

    // Model state: what the renderer remembers between frames.
    int pvx[2], pvy[2];
    bit pvv[2];
    bit exp_ov = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int pack_pix(input int px, input int py, input int c);
        return (px << 16) | (py << 4) | c;
    endfunction

    // Monitor: every accepted pixel must be the next expected one; a stalled pixel must hold.
    always @(negedge clock) begin
        if (!resetn) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                chk("stall_hold_plot", int'(plot), 1);
                chk("stall_hold_pix", pack_pix(int'(x), int'(y), int'(colour)), hold_pix);
            end
            hold_prev = plot && stall;
            hold_pix  = pack_pix(int'(x), int'(y), int'(colour));
            if (plot && !stall) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    chk("pixel_unexpected", hold_pix, -1);
                end else begin
                    chk("pixel", hold_pix, exp_q.pop_front());
                end
            end
        end
    end

    // Sink back-pressure: none, random, or one 5-cycle stall at pixel 10.
    always begin
        @(posedge clock);
        #1;
        if (smode == 1) begin
            stall = ($urandom_range(0, 3) == 0);
        end else if (smode == 2 && !stall_fired && acc_cnt == 10) begin
            stall_fired = 1;
            stall = 1'b1;
            repeat (5) @(posedge clock);
            #1 stall = 1'b0;
        end else begin
            stall = 1'b0;
        end
    end

    // Expected pixels and busy length for one frame, straight from the sprite rules.
    function automatic int model_frame(input bit en[2], input int ox[2], input int oy[2],
                                       input int oc[2], output int n_plots);
        int cyc = 2;  // LOAD + DONE
        n_plots = 0;
        for (int i = 0; i < 2; i++) begin
            if (pvv[i]) begin
                cyc += 256;
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++)
                        if (pvx[i] + c < 160 && pvy[i] + r < 120) begin
                            exp_q.push_back(pack_pix(pvx[i] + c, pvy[i] + r, 0));
                            n_plots++;
                        end
            end
            if (en[i]) begin
                cyc += 256;
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++)
                        if (ox[i] + c < 160 && oy[i] + r < 120) begin
                            exp_q.push_back(pack_pix(ox[i] + c, oy[i] + r, oc[i]));
                            n_plots++;
                        end
            end
            cyc += 1;  // NEXT
            pvv[i] = en[i];
            pvx[i] = ox[i];
            pvy[i] = oy[i];
        end
        return cyc;
    endfunction

    task automatic do_reset_checks(input string tag);
        @(negedge clock);
        chk({tag, "_plot"}, int'(plot), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_xyc"}, pack_pix(int'(x), int'(y), int'(colour)), 0);
        exp_q.delete();
        pvv[0] = 0;
        pvv[1] = 0;
        exp_ov = 0;
    endtask

    // Run one frame. tick_at/abort_at: accepted-pixel count at which to pulse
    // frame_tick or pulse reset (0 = never). exp_stall >= 0 pins the stall-cycle count.
    task automatic do_frame(input logic [1:0] en_v, input int x0, input int y0, input int c0,
                            input int x1, input int y1, input int c1, input int mode,
                            input int tick_at, input int abort_at, input int exp_stall);
        bit en[2];
        int ox[2], oy[2], oc[2];
        int exp_len, n_plots, busy_cnt, stall_cnt;
        bit got_done, ticked;
        en[0] = en_v[0]; en[1] = en_v[1];
        ox[0] = x0; ox[1] = x1; oy[0] = y0; oy[1] = y1; oc[0] = c0; oc[1] = c1;
        exp_len = model_frame(en, ox, oy, oc, n_plots);
        @(posedge clock);
        #1;
        obj_en = en_v;
        obj_x = {8'(x1), 8'(x0)};
        obj_y = {7'(y1), 7'(y0)};
        obj_colour = {3'(c1), 3'(c0)};
        acc_cnt = 0;
        stall_fired = 0;
        smode = mode;
        frame_tick = 1'b1;
        @(posedge clock);
        #1 frame_tick = 1'b0;
        busy_cnt = 0; stall_cnt = 0; got_done = 0; ticked = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            if (busy) busy_cnt++;
            if (plot && stall) stall_cnt++;
            if (done) begin
                got_done = 1;
                break;
            end
            @(posedge clock);
            #1;
            // Inputs change mid-frame; the snapshot must shield the frame.
            obj_en = 2'($urandom);
            obj_x = 16'($urandom);
            obj_y = 14'($urandom);
            obj_colour = 6'($urandom);
            frame_tick = 1'b0;
            if (tick_at != 0 && !ticked && acc_cnt >= tick_at) begin
                ticked = 1;
                frame_tick = 1'b1;
                exp_ov = 1;
            end
            if (abort_at != 0 && acc_cnt >= abort_at) begin
                smode = 0;
                resetn = 1'b0;
                @(posedge clock);
                #1 resetn = 1'b1;
                do_reset_checks("abort");
                return;
            end
        end
        smode = 0;
        chk("frame_done_seen", int'(got_done), 1);
        chk("busy_len", busy_cnt, exp_len + stall_cnt);
        chk("plot_count", acc_cnt, n_plots);
        chk("queue_empty", exp_q.size(), 0);
        chk("overrun", int'(overrun), int'(exp_ov));
        if (exp_stall >= 0) chk("stall_cycles", stall_cnt, exp_stall);
        exp_q.delete();
        @(negedge clock);
        chk("done_pulse", int'(done), 0);
        chk("busy_after", int'(busy), 0);
    endtask

    initial begin
        pvv[0] = 0; pvv[1] = 0;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        do_reset_checks("reset");

        // Two on-screen sprites, then obj0 moves (erase + draw), then obj1 clipped.
        do_frame(2'b11, 20, 60, 4, 140, 104, 1, 0, 0, 0, 0);
        do_frame(2'b11, 20, 58, 4, 140, 104, 1, 0, 0, 0, 0);
        do_frame(2'b11, 20, 58, 4, 150, 110, 5, 0, 0, 0, 0);

        // Fresh reset; 5-cycle stall inside obj0 draw.
        @(posedge clock);
        #1 resetn = 1'b0;
        @(posedge clock);
        #1 resetn = 1'b1;
        do_reset_checks("reset2");
        do_frame(2'b11, 20, 60, 4, 140, 104, 1, 2, 0, 0, 5);

        // frame_tick mid-draw sets sticky overrun; then erase-only frame.
        do_frame(2'b11, 30, 40, 6, 100, 20, 2, 0, 300, 0, 0);
        chk("overrun_sticky", int'(overrun), 1);
        do_frame(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("overrun_sticky2", int'(overrun), 1);

        // Reset mid obj1 draw, then a frame that must not erase.
        do_frame(2'b11, 5, 5, 3, 60, 60, 7, 0, 0, 300, -1);
        do_frame(2'b11, 5, 5, 3, 60, 60, 7, 0, 0, 0, 0);

        // Random frames with random back-pressure, including off-screen positions.
        for (int k = 0; k < 6; k++) begin
            do_frame(2'($urandom), $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 7), 1, 0, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
